// File: rtl/sync_fifo_rd_stream.sv
// Read-side adapter for a first-word-fall-through sync FIFO: pops words into a
// two-entry head/skid stage and presents them as a registered valid/ready stream.
module sync_fifo_rd_stream #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_fifo_rdata,
  input  logic             i_fifo_not_empty,
  output logic             o_fifo_pop,
  output logic             o_fifo_flush,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic [1:0]       o_occ,
  output logic [CNT_W-1:0] o_xfer_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] head_p0_q, head_p0_d;
  logic [WIDTH-1:0] skid_p1_q, skid_p1_d;
  logic [CNT_W-1:0] cnt_q;
  logic             vld_p0;
  logic             acc;
  logic             space;

  // The state encoding doubles as the occupancy count.
  assign vld_p0       = (state_q != S_EMPTY);
  assign acc          = vld_p0 & i_ready;
  assign space        = (state_q != S_TWO) | acc;
  assign o_fifo_pop   = i_fifo_not_empty & space & ~i_flush;
  assign o_fifo_flush = i_flush;
  assign o_valid      = vld_p0;
  assign o_data       = head_p0_q;
  assign o_occ        = state_q;
  assign o_xfer_cnt   = cnt_q;

  always_comb begin
    state_d   = state_q;
    head_p0_d = head_p0_q;
    skid_p1_d = skid_p1_q;
    if (i_flush) begin
      state_d   = S_EMPTY;
      head_p0_d = '0;
      skid_p1_d = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (o_fifo_pop) begin
            head_p0_d = i_fifo_rdata;
            state_d   = S_ONE;
          end
        end
        S_ONE: begin
          if (o_fifo_pop && !acc) begin
            skid_p1_d = i_fifo_rdata;
            state_d   = S_TWO;
          end else if (o_fifo_pop && acc) begin
            head_p0_d = i_fifo_rdata;
          end else if (acc) begin
            head_p0_d = '0;
            state_d   = S_EMPTY;
          end
        end
        S_TWO: begin
          // A full stage only refills while the head is being accepted.
          if (acc) begin
            head_p0_d = skid_p1_q;
            if (o_fifo_pop) begin
              skid_p1_d = i_fifo_rdata;
            end else begin
              skid_p1_d = '0;
              state_d   = S_ONE;
            end
          end
        end
        default: begin
          state_d   = S_EMPTY;
          head_p0_d = '0;
          skid_p1_d = '0;
        end
      endcase
    end
  end

  // Stage registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_EMPTY;
      head_p0_q <= '0;
      skid_p1_q <= '0;
    end else begin
      state_q   <= state_d;
      head_p0_q <= head_p0_d;
      skid_p1_q <= skid_p1_d;
    end
  end

  // Transfer counter keeps counting through flushes, including the flush cycle itself.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, acc};
    end
  end

endmodule
